seq_gen_10010: RTL and testbench

//   Serial pattern transmitter; the generating end of the 10010 sequence-detector link.
//   On start, emits PATTERN MSB-first, one bit per accepted beat, repeated BURST times.

---
 rtl/seq_gen_10010.sv | 213 +++++++++++++++++++++
 tb/tb_seq_gen_10010.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_10010.sv
// -----------------------------------------------------------------------------
// seq_gen_10010
//   Serial pattern transmitter feeding the 10010 sequence-detector link.
//   On an accepted start the block sends PATTERN MSB-first, one bit per
//   accepted beat, repeated 'burst' times. Repetitions either share an
//   overlapping prefix/suffix (GAP_LEN == 0, first OVL_LEN bits skipped on
//   repeats 2..N) or are separated by GAP_LEN idle cycles (full pattern each time).
//
// Parameters
//   PAT_LEN  pattern length in bits (2..32)
//   PATTERN  bit pattern, bit PAT_LEN-1 is sent first
//   OVL_LEN  leading bits skipped on repetitions 2..N when GAP_LEN == 0
//   GAP_LEN  idle cycles between repetitions (0..255); >0 disables overlap
//
// Ports
//   clk        clock
//   rst        synchronous reset, active-high
//   start      launch request, only looked at in IDLE
//   burst[7:0] repetition count, latched on an accepted start (0 = ignore start)
//   abort      cancel the current transfer (SEND/GAP/DONE -> IDLE)
//   dout       serial data bit
//   dout_vld   dout valid
//   dout_rdy   downstream accepts dout this cycle
//   busy       high from the cycle after an accepted start until back in IDLE
//   done       one-cycle pulse after the last bit of the last repetition
//   state_dbg  current FSM state (debug visibility)
//   pat_cnt    completed-repetition counter, saturating; present only when
//              the macro SEQ_GEN_PAT_CNT_EN is defined
//
// Handshake: a beat happens on a cycle where dout_vld && dout_rdy. While
// dout_vld is high and dout_rdy is low, dout and dout_vld are held unchanged,
// so no bit is lost or repeated. dout_vld never drops without a beat except
// on abort or reset.
// -----------------------------------------------------------------------------
module seq_gen_10010 #(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b10010,
  parameter int                 OVL_LEN = 2,
  parameter int                 GAP_LEN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] burst,
  input  logic       abort,
  output logic       dout,
  output logic       dout_vld,
  input  logic       dout_rdy,
  output logic       busy,
  output logic       done,
  output logic [1:0] state_dbg
`ifdef SEQ_GEN_PAT_CNT_EN
  ,
  output logic [15:0] pat_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Pattern widened to 32 bits so a 5-bit index always fits exactly.
  localparam logic [31:0] PAT32   = 32'(PATTERN);
  localparam logic [4:0]  IDX_TOP = 5'(PAT_LEN - 1);
  localparam logic [4:0]  IDX_OVL = 5'(PAT_LEN - 1 - OVL_LEN);
  localparam logic [7:0]  GAP_TOP = 8'(GAP_LEN - 1);

  state_t     state, state_nxt;
  logic [4:0] idx, idx_nxt;       // bit index currently (or about to be) presented
  logic [7:0] rep, rep_nxt;       // repetitions still to send, including current
  logic [7:0] gap_cnt, gap_nxt;   // remaining idle cycles minus one
  logic       dout_nxt, vld_nxt, busy_nxt, done_nxt;
  logic       beat;

  assign beat      = dout_vld && dout_rdy;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rep_nxt   = rep;
    gap_nxt   = gap_cnt;
    dout_nxt  = dout;
    vld_nxt   = dout_vld;
    busy_nxt  = busy;
    done_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        dout_nxt = 1'b0;
        vld_nxt  = 1'b0;
        busy_nxt = 1'b0;
        // abort outranks start even here; burst == 0 is a no-op request
        if (start && (burst != 8'd0) && !abort) begin
          state_nxt = S_SEND;
          idx_nxt   = IDX_TOP;
          rep_nxt   = burst;
          busy_nxt  = 1'b1;
        end
      end

      S_SEND: begin
        if (abort) begin
          state_nxt = S_IDLE;
          dout_nxt  = 1'b0;
          vld_nxt   = 1'b0;
          busy_nxt  = 1'b0;
        end else if (!dout_vld) begin
          // First cycle after start: present the first bit (one-cycle latency).
          dout_nxt = PAT32[idx];
          vld_nxt  = 1'b1;
        end else if (beat) begin
          if (idx == 5'd0) begin
            if (rep == 8'd1) begin
              state_nxt = S_DONE;
              dout_nxt  = 1'b0;
              vld_nxt   = 1'b0;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              rep_nxt = rep - 8'd1;
              if (GAP_LEN == 0) begin
                // Overlapped repeat: jump past the shared prefix, no bubble.
                idx_nxt  = IDX_OVL;
                dout_nxt = PAT32[IDX_OVL];
              end else begin
                state_nxt = S_GAP;
                idx_nxt   = IDX_TOP;
                gap_nxt   = GAP_TOP;
                dout_nxt  = 1'b0;
                vld_nxt   = 1'b0;
              end
            end
          end else begin
            idx_nxt  = idx - 5'd1;
            dout_nxt = PAT32[idx - 5'd1];
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          state_nxt = S_IDLE;
          dout_nxt  = 1'b0;
          vld_nxt   = 1'b0;
          busy_nxt  = 1'b0;
        end else if (gap_cnt == 8'd0) begin
          // Load the first bit on the last idle cycle so the gap is exactly GAP_LEN.
          state_nxt = S_SEND;
          dout_nxt  = PAT32[idx];
          vld_nxt   = 1'b1;
        end else begin
          gap_nxt = gap_cnt - 8'd1;
        end
      end

      S_DONE: begin
        // done is high for this single cycle; abort leads to the same place.
        state_nxt = S_IDLE;
        dout_nxt  = 1'b0;
        vld_nxt   = 1'b0;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = S_IDLE;
        dout_nxt  = 1'b0;
        vld_nxt   = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= IDX_TOP;
      rep      <= 8'd0;
      gap_cnt  <= 8'd0;
      dout     <= 1'b0;
      dout_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      rep      <= rep_nxt;
      gap_cnt  <= gap_nxt;
      dout     <= dout_nxt;
      dout_vld <= vld_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

`ifdef SEQ_GEN_PAT_CNT_EN
  // A repetition completes on the beat of bit 0; abort suppresses that beat.
  logic rep_done;
  assign rep_done = (state == S_SEND) && !abort && beat && (idx == 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_cnt <= 16'd0;
    end else if (rep_done && (pat_cnt != 16'hFFFF)) begin
      pat_cnt <= pat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_gen_10010.sv
// -----------------------------------------------------------------------------
// tb_seq_gen_10010
//   Two instances share all inputs: g_chk[0] overlapped repeats (GAP_LEN=0),
//   g_chk[1] gapped repeats (GAP_LEN=4). Each has a queue-based model: on an
//   accepted start it expands the burst into the sequence of cycles it must
//   produce (lead cycle, pattern bits, gap cycles, done cycle); bits wait for
//   dout_rdy, everything else lasts one cycle. Outputs are compared every
//   cycle on the falling edge. Directed runs pin the model with literal streams.
// -----------------------------------------------------------------------------
module tb_seq_gen_10010;
  localparam int         PAT_LEN = 5;
  localparam logic [4:0] PATTERN = 5'b10010;
  localparam int         OVL_LEN = 2;
  localparam int         N_DUT   = 2;

  localparam logic [1:0] K_LEAD = 2'd0;
  localparam logic [1:0] K_BIT  = 2'd1;
  localparam logic [1:0] K_GAP  = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       dout_rdy = 1'b0;
  logic [7:0] burst = 8'd0;
  bit         armed = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int k);
    n_tests++;
    n_fail++;
    $display("FAIL %s: condition not reached within %0d cycles", name, k);
  endtask

  // overlapped occurrences of PATTERN in the newest n captured bits
  function automatic int count_pat(input logic [63:0] s, input int n);
    int c = 0;
    for (int i = 0; i + PAT_LEN <= n; i++)
      if (((s >> i) & 64'h1F) == 64'(PATTERN)) c++;
    return c;
  endfunction

  for (genvar g = 0; g < N_DUT; g++) begin : g_chk
    localparam int GAP = g * 4;
    logic        dout, vld, busy, done;
    logic [1:0]  st;
    logic [3:0]  exp_q[$];   // {kind[1:0], bit, last_of_rep}
    logic [63:0] cap = 64'd0;
    int          cap_n = 0;
    int          beats = 0;
    int          idle_lo = 0;
    int          done_n = 0;
    int          cur_burst = 0;
`ifdef SEQ_GEN_PAT_CNT_EN
    logic [15:0] pat_cnt;
    logic [15:0] exp_cnt = 16'd0;
`endif

    seq_gen_10010 #(
      .PAT_LEN(PAT_LEN), .PATTERN(PATTERN), .OVL_LEN(OVL_LEN), .GAP_LEN(GAP)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .burst(burst), .abort(abort),
      .dout(dout), .dout_vld(vld), .dout_rdy(dout_rdy), .busy(busy), .done(done),
      .state_dbg(st)
`ifdef SEQ_GEN_PAT_CNT_EN
      , .pat_cnt(pat_cnt)
`endif
    );

    function automatic void build(input int nb);
      exp_q.push_back({K_LEAD, 2'b00});
      for (int r = 0; r < nb; r++) begin
        int top;
        top = (r > 0 && GAP == 0) ? PAT_LEN - 1 - OVL_LEN : PAT_LEN - 1;
        if (r > 0) for (int k = 0; k < GAP; k++) exp_q.push_back({K_GAP, 2'b00});
        for (int i = top; i >= 0; i--) exp_q.push_back({K_BIT, PATTERN[i], (i == 0)});
      end
      exp_q.push_back({K_DONE, 2'b00});
    endfunction

    // model advance + capture of accepted DUT bits
    always @(posedge clk) begin
      logic [3:0] h;
      if (rst) begin
        exp_q.delete();
`ifdef SEQ_GEN_PAT_CNT_EN
        exp_cnt = 16'd0;
`endif
      end else begin
        if (vld && dout_rdy) begin
          cap = {cap[62:0], dout};
          cap_n++;
          beats++;
        end
        if (busy && !vld) idle_lo++;
        if (done) done_n++;
        if (exp_q.size() != 0) begin
          h = exp_q[0];
          if (abort) begin
            exp_q.delete();
          end else if (h[3:2] == K_BIT) begin
            if (dout_rdy) begin
`ifdef SEQ_GEN_PAT_CNT_EN
              if (h[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
              void'(exp_q.pop_front());
            end
          end else begin
            if (h[3:2] == K_DONE) begin
              chk($sformatf("g%0d_beats_per_burst", g), 64'(beats),
                  64'((GAP == 0) ? PAT_LEN + (cur_burst - 1) * (PAT_LEN - OVL_LEN)
                                 : cur_burst * PAT_LEN));
              chk($sformatf("g%0d_idle_cycles", g), 64'(idle_lo),
                  64'(1 + (cur_burst - 1) * GAP));
            end
            void'(exp_q.pop_front());
          end
        end else if (start && burst != 8'd0 && !abort) begin
          cur_burst = int'(burst);
          cap = 64'd0; cap_n = 0; beats = 0; idle_lo = 0;
          build(cur_burst);
        end
      end
    end

    // compare process
    always @(negedge clk) begin
      logic [3:0] h;
      logic       has, e_vld, e_dout, e_busy, e_done;
      if (armed) begin
        has    = (exp_q.size() != 0);
        h      = has ? exp_q[0] : 4'b0000;
        e_vld  = has && (h[3:2] == K_BIT);
        e_dout = e_vld && h[1];
        e_busy = has && (h[3:2] != K_DONE);
        e_done = has && (h[3:2] == K_DONE);
        chk($sformatf("g%0d_outputs{dout,vld,busy,done}", g),
            {dout, vld, busy, done}, {e_dout, e_vld, e_busy, e_done});
`ifdef SEQ_GEN_PAT_CNT_EN
        chk($sformatf("g%0d_pat_cnt", g), pat_cnt, exp_cnt);
`endif
      end
    end
  end

  // driver tasks
  task automatic launch(input logic [7:0] b);
    start = 1'b1;
    burst = b;
    @(negedge clk);
    start = 1'b0;
    burst = 8'd0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((g_chk[0].busy || g_chk[0].done || g_chk[1].busy || g_chk[1].done) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) timeout(name, k);
    @(negedge clk);
  endtask

  task automatic wait_bits(input int n, input string name);
    int k = 0;
    while (!(g_chk[0].cap_n == n && g_chk[0].vld) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) timeout(name, k);
  endtask

  initial begin
    int d0, d1;
    repeat (3) @(negedge clk);
    chk("reset_g0", {g_chk[0].dout, g_chk[0].vld, g_chk[0].busy, g_chk[0].done}, 4'b0000);
    chk("reset_g1", {g_chk[1].dout, g_chk[1].vld, g_chk[1].busy, g_chk[1].done}, 4'b0000);
    armed = 1'b1;
    rst = 1'b0;
    dout_rdy = 1'b1;
    @(negedge clk);

    // 1: single pattern, latency and done
    d0 = g_chk[0].done_n;
    launch(8'd1);
    chk("t1_lead{vld,busy}", {g_chk[0].vld, g_chk[0].busy}, 2'b01);
    @(negedge clk);
    chk("t1_first{vld,dout}", {g_chk[0].vld, g_chk[0].dout}, 2'b11);
    wait_idle("t1_idle");
    chk("t1_stream", {g_chk[0].cap_n[7:0], g_chk[0].cap[4:0]}, {8'd5, 5'b10010});
    chk("t1_done_count", g_chk[0].done_n - d0, 1);

    // 2: burst 3, overlapped vs gapped
    launch(8'd3);
    wait_idle("t2_idle");
    chk("t2_g0_stream", {g_chk[0].cap_n[7:0], g_chk[0].cap[10:0]}, {8'd11, 11'b10010010010});
    chk("t2_g0_detect", count_pat(g_chk[0].cap, g_chk[0].cap_n), 3);
    chk("t2_g1_stream", {g_chk[1].cap_n[7:0], g_chk[1].cap[14:0]}, {8'd15, 15'b100101001010010});

    // 3: back-pressure while bit index 3 (value 0) is presented
    launch(8'd1);
    wait_bits(1, "t3_wait");
    dout_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold{vld,dout}", {g_chk[0].vld, g_chk[0].dout}, 2'b10);
    end
    dout_rdy = 1'b1;
    wait_idle("t3_idle");
    chk("t3_stream", {g_chk[0].cap_n[7:0], g_chk[0].cap[4:0]}, {8'd5, 5'b10010});

    // 4: burst 2, gap of 4 idle cycles on g1
    launch(8'd2);
    wait_idle("t4_idle");
    chk("t4_g1_stream", {g_chk[1].cap_n[7:0], g_chk[1].cap[9:0]}, {8'd10, 10'b1001010010});
    chk("t4_g1_idle_cycles", g_chk[1].idle_lo, 5);
    chk("t4_g0_stream", {g_chk[0].cap_n[7:0], g_chk[0].cap[7:0]}, {8'd8, 8'b10010010});

    // 5: abort on third bit, then start with burst 0
    d0 = g_chk[0].done_n;
    d1 = g_chk[1].done_n;
    launch(8'd2);
    wait_bits(2, "t5_wait");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("t5_abort{vld,busy}", {g_chk[0].vld, g_chk[0].busy, g_chk[1].vld, g_chk[1].busy}, 4'b0000);
    repeat (3) @(negedge clk);
    chk("t5_no_done", (g_chk[0].done_n - d0) + (g_chk[1].done_n - d1), 0);
    launch(8'd0);
    @(negedge clk);
    chk("t5_burst0_idle{busy,vld}", {g_chk[0].busy, g_chk[0].vld}, 2'b00);

`ifdef SEQ_GEN_PAT_CNT_EN
    // 6: completed-repetition counter
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    launch(8'd3);
    wait_idle("t6_idle_a");
    launch(8'd3);
    wait_idle("t6_idle_b");
    chk("t6_pat_cnt", g_chk[0].pat_cnt, 16'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_pat_cnt_rst", g_chk[0].pat_cnt, 16'd0);
`endif

    // 7: reset mid-burst, then a clean burst
    launch(8'd3);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_outputs", {g_chk[0].dout, g_chk[0].vld, g_chk[0].busy, g_chk[0].done}, 4'b0000);
    rst = 1'b0;
    @(negedge clk);
    launch(8'd1);
    wait_idle("t7_idle");
    chk("t7_stream", {g_chk[0].cap_n[7:0], g_chk[0].cap[4:0]}, {8'd5, 5'b10010});

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      dout_rdy = ($urandom_range(0, 3) != 0);
      start    = ($urandom_range(0, 5) == 0);
      burst    = 8'($urandom_range(0, 4));
      abort    = ($urandom_range(0, 59) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    dout_rdy = 1'b1;
    wait_idle("rand_idle");

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
